// File: rtl/traffic_pkg.sv
// traffic_pkg: shared channel states, channel indices and default conflict mask
package traffic_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, GREEN, YELLOW, CLEAR} state_t;
  localparam int CH_PED  = 0;
  localparam int CH_UP   = 1;
  localparam int CH_DOWN = 2;
  localparam int CH_TURN = 3;
  localparam logic [15:0] DEFAULT_CONFLICT = 16'h4916;
endpackage

// File: rtl/channel_fsm.sv
// channel_fsm: one signal channel's light state machine and saturating dwell counter
module channel_fsm
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN   = 4,
  parameter int YELLOW_TIME = 2,
  parameter int ALL_RED     = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic request,
  input  logic grant,
  input  logic conflict_wait,
  output logic occupied,
  output logic green,
  output logic yellow,
  output logic red,
  output logic waiting
);
  state_t state, nxt;
  logic [7:0] cnt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = request ? WAIT : IDLE;
      WAIT:    nxt = !request ? IDLE : grant ? GREEN : WAIT;
      GREEN:   nxt = (cnt >= 8'(MIN_GREEN - 1) && (!request || conflict_wait)) ? YELLOW : GREEN;
      YELLOW:  nxt = (cnt == 8'(YELLOW_TIME - 1)) ? CLEAR : YELLOW;
      CLEAR:   nxt = (cnt == 8'(ALL_RED - 1)) ? (request ? WAIT : IDLE) : CLEAR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 8'd0 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end
  end
  assign green    = state == GREEN;
  assign yellow   = state == YELLOW;
  assign red      = !green && !yellow;
  assign waiting  = state == WAIT;
  assign occupied = green || yellow || state == CLEAR;
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: conflict-aware round-robin grant scan over N channel state machines
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int             N           = 4,
  parameter logic [N*N-1:0] CONFLICT    = DEFAULT_CONFLICT,
  parameter int             MIN_GREEN   = 4,
  parameter int             YELLOW_TIME = 2,
  parameter int             ALL_RED     = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] request,
  output logic [N-1:0] green,
  output logic [N-1:0] yellow,
  output logic [N-1:0] red,
  output logic [N-1:0] waiting
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [N-1:0] occ, grant, cwait;
  logic [PW-1:0] ptr, ptr_nxt;
  logic found;
  int idx;
  // ptr moves past the first grant so channels granted together cannot win every round
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (waiting[idx] && request[idx] && ((occ | grant) & CONFLICT[idx*N +: N]) == '0) begin
        grant[idx] = 1'b1;
        ptr_nxt    = found ? ptr_nxt : PW'((idx + 1) % N);
        found      = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) ptr <= '0;
    else ptr <= ptr_nxt;
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign cwait[i] = |(CONFLICT[i*N +: N] & waiting);
    channel_fsm #(
      .MIN_GREEN(MIN_GREEN),
      .YELLOW_TIME(YELLOW_TIME),
      .ALL_RED(ALL_RED)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .request(request[i]),
      .grant(grant[i]),
      .conflict_wait(cwait[i]),
      .occupied(occ[i]),
      .green(green[i]),
      .yellow(yellow[i]),
      .red(red[i]),
      .waiting(waiting[i])
    );
  end
endmodule
